// File: rtl/mul_pkg.sv
// Shared definitions for the iterative RV32M multiplier: mulsel encodings,
// FSM state type and the legal-opcode helper.
package mul_pkg;

  localparam logic [2:0] MUL_LO  = 3'b001;
  localparam logic [2:0] MUL_HSS = 3'b010;
  localparam logic [2:0] MUL_HSU = 3'b011;
  localparam logic [2:0] MUL_HUU = 3'b100;

  typedef enum logic [1:0] {IDLE, CALC, SIGN} mul_state_t;

  function automatic logic is_legal_sel(input logic [2:0] sel);
    return (sel == MUL_LO) || (sel == MUL_HSS) || (sel == MUL_HSU) || (sel == MUL_HUU);
  endfunction

endpackage

// File: rtl/mul_shift_add_core.sv
// Unsigned XLEN x XLEN radix-2 shift-add datapath: load clears the
// accumulator, each step consumes one multiplier bit.
module mul_shift_add_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [XLEN-1:0]   mcand_i,
  input  logic [XLEN-1:0]   mplier_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              cnt_last_o
);

  localparam int CW = $clog2(XLEN);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // The multiplicand register is shifted each step, so it always equals mcand << cnt.
  always_comb begin
    // NOTE: every next-state value is defaulted to its register first so no path leaves it unassigned and no latch is inferred.
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = {{XLEN{1'b0}}, mcand_i};
      mplier_d = mplier_i;
      cnt_d    = '0;
    end else if (step) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc_o      = acc_q;
  assign cnt_last_o = (cnt_q == CW'(XLEN - 1));

endmodule

// File: rtl/mul_iter_unit.sv
// Multi-cycle RV32M multiplier (MUL/MULH/MULHSU/MULHU): sign/magnitude
// front end, shift-add core, sign fix-up and half select.
module mul_iter_unit
  import mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      mulsel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mul_state_t        state_q;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   result_q;
  logic              done_q;

  logic              launch;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] product;
  logic              cnt_last;

  assign launch = (state_q == IDLE) && start && !flush && is_legal_sel(mulsel);

  // Only operands treated as signed contribute a sign; the magnitude of the
  // most negative value wraps to 2^(XLEN-1), which is correct as unsigned.
  assign sign_a = op_a[XLEN-1] && ((mulsel == MUL_HSS) || (mulsel == MUL_HSU));
  assign sign_b = op_b[XLEN-1] && (mulsel == MUL_HSS);
  assign mag_a  = sign_a ? (~op_a + XLEN'(1)) : op_a;
  assign mag_b  = sign_b ? (~op_b + XLEN'(1)) : op_b;

  mul_shift_add_core #(.XLEN(XLEN)) u_core (
    .clk        (clk),
    .rst        (rst),
    .load       (launch),
    .step       (state_q == CALC),
    .mcand_i    (mag_a),
    .mplier_i   (mag_b),
    .acc_o      (acc),
    .cnt_last_o (cnt_last)
  );

  assign product = neg_q ? (~acc + (2*XLEN)'(1)) : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (launch) begin
          state_q <= CALC;
          op_q    <= mulsel;
          neg_q   <= sign_a ^ sign_b;
        end
        CALC: begin
          if (flush)         state_q <= IDLE;
          else if (cnt_last) state_q <= SIGN;
        end
        SIGN: begin
          state_q <= IDLE;
          if (!flush) begin
            result_q <= (op_q == MUL_LO) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
            done_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Self-checking bench for mul_iter_unit: directed corner cases plus random
// operations against a 64-bit arithmetic reference.
module tb_mul_iter_unit;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  mulsel;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_iter_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mulsel (mulsel),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax, bx, p;
    ax = ((sel == MUL_HSS) || (sel == MUL_HSU)) ? {{32{a[31]}}, a} : {32'b0, a};
    bx = (sel == MUL_HSS) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ax * bx;
    return (sel == MUL_LO) ? p[31:0] : p[63:32];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered at a negedge; leaves at the negedge of cycle 1 with inputs scrambled.
  task automatic launch(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    mulsel = sel;
    op_a   = a;
    op_b   = b;
    tick();
    start  = 1'b0;
    mulsel = 3'($urandom);
    op_a   = $urandom;
    op_b   = $urandom;
  endtask

  task automatic wait_done(output int cyc, output int busy_bad);
    cyc      = 1;
    busy_bad = 0;
    while (!done && cyc < 60) begin
      if (!busy) busy_bad++;
      tick();
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  task automatic count_dones(input int n, output int dn);
    dn = 0;
    repeat (n) begin
      tick();
      if (done) dn++;
    end
  endtask

  // Leaves the bench at the negedge of the done cycle.
  task automatic run_check(input string tag, input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    int cyc, bb;
    launch(sel, a, b);
    wait_done(cyc, bb);
    check({tag, " latency"}, 64'(cyc), 64'd34);
    check({tag, " busy"}, 64'(bb), 64'd0);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " result"}, 64'(result), 64'(ref_mul(sel, a, b)));
  endtask

  initial begin
    logic [2:0]  sels [4];
    logic [31:0] corners [5];
    logic [31:0] prev, a, b;
    logic [2:0]  sel;
    int dn, cyc, bb;

    sels    = '{MUL_LO, MUL_HSS, MUL_HSU, MUL_HUU};
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    rst = 1'b1; start = 1'b0; flush = 1'b0; mulsel = 3'b000; op_a = '0; op_b = '0;
    repeat (3) tick();
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", 64'(result), 64'd0);
    rst = 1'b0;
    tick();

    run_check("mul_7x-3", MUL_LO, 32'd7, 32'hFFFF_FFFD);
    check("mul_7x-3 const", 64'(result), 64'hFFFF_FFEB);
    tick();
    run_check("mulh_min", MUL_HSS, 32'h8000_0000, 32'h8000_0000);
    check("mulh_min const", 64'(result), 64'h4000_0000);
    tick();
    run_check("mulh_m1", MUL_HSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulh_m1 const", 64'(result), 64'h0);
    tick();
    run_check("mulhsu_m1", MUL_HSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhsu_m1 const", 64'(result), 64'hFFFF_FFFF);
    tick();
    run_check("mulhu_max", MUL_HUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhu_max const", 64'(result), 64'hFFFF_FFFE);
    tick();

    // Flush in CALC cycle 10: no done, result kept, then a normal op.
    prev = result;
    launch(MUL_LO, 32'd1234, 32'd5678);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_calc busy", 64'(busy), 64'd0);
    check("flush_calc done", 64'(done), 64'd0);
    count_dones(40, dn);
    check("flush_calc no_done", 64'(dn), 64'd0);
    check("flush_calc result_kept", 64'(result), 64'(prev));
    run_check("after_flush", MUL_HSU, 32'h8765_4321, 32'h1234_5678);
    tick();

    // Flush in the SIGN cycle.
    prev = result;
    launch(MUL_HSS, 32'h0000_0003, 32'hFFFF_0000);
    repeat (32) tick();
    check("flush_sign busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_sign done", 64'(done), 64'd0);
    check("flush_sign busy", 64'(busy), 64'd0);
    count_dones(40, dn);
    check("flush_sign no_done", 64'(dn), 64'd0);
    check("flush_sign result_kept", 64'(result), 64'(prev));

    // Flush together with start in IDLE: nothing launched.
    flush = 1'b1;
    launch(MUL_LO, 32'd5, 32'd6);
    flush = 1'b0;
    check("flush_start busy", 64'(busy), 64'd0);
    count_dones(40, dn);
    check("flush_start no_done", 64'(dn), 64'd0);

    // Illegal opcodes are ignored.
    foreach (corners[i]) begin
      if (i < 3) begin
        sel = (i == 0) ? 3'b101 : (i == 1) ? 3'b000 : 3'b111;
        launch(sel, 32'd9, 32'd9);
        check($sformatf("illegal_%0b busy", sel), 64'(busy), 64'd0);
        count_dones(40, dn);
        check($sformatf("illegal_%0b no_done", sel), 64'(dn), 64'd0);
      end
    end

    // Start while busy is ignored: one done, first operation's result.
    a = 32'hDEAD_BEEF; b = 32'h0000_1001;
    launch(MUL_HUU, a, b);
    repeat (4) tick();
    start = 1'b1; mulsel = MUL_LO; op_a = 32'd3; op_b = 32'd4;
    tick();
    start = 1'b0;
    wait_done(cyc, bb);
    check("busy_start latency", 64'(cyc), 64'd29);
    check("busy_start result", 64'(result), 64'(ref_mul(MUL_HUU, a, b)));
    count_dones(40, dn);
    check("busy_start single_done", 64'(dn), 64'd0);

    // Back-to-back issue in the done cycle.
    run_check("b2b_first", MUL_HSS, 32'hFFFF_FFF9, 32'd11);
    run_check("b2b_second", MUL_LO, 32'h0001_0001, 32'h0001_0001);
    tick();

    // Randomized operations, mixing idle gaps and back-to-back issue.
    for (int n = 0; n < 30; n++) begin
      sel = sels[$urandom_range(0, 3)];
      a   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
      run_check($sformatf("rand%0d_sel%0b", n, sel), sel, a, b);
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();

    // Reset mid-CALC returns everything to zero, with no done afterwards.
    run_check("pre_reset", MUL_LO, 32'd7, 32'hFFFF_FFFD);
    tick();
    launch(MUL_HUU, 32'hFFFF_FFFF, 32'h2);
    repeat (14) tick();
    rst = 1'b1;
    tick();
    check("rst_mid busy", 64'(busy), 64'd0);
    check("rst_mid done", 64'(done), 64'd0);
    check("rst_mid result", 64'(result), 64'd0);
    rst = 1'b0;
    count_dones(40, dn);
    check("rst_mid no_done", 64'(dn), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
